// File: rtl/imem_loader_rv32i.sv
// Boot loader: packs a byte stream into little-endian words for the 32-word RV32I instruction memory and holds the core in reset until the load finishes.
// Latency: imem_we pulses in the cycle right after the 4th byte handshake of a word; one word takes at least 5 cycles.
// Backpressure: byte_ready is high only in COLLECT and drops for the single WRITE cycle; an idle stream stalls with no timeout.
module imem_loader_rv32i #(
   parameter int DEPTH_WORDS = 32,
   parameter int ADDR_W      = 5
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic              abort,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic [7:0]        checksum,
   output logic              busy,
   output logic              done,
   output logic              cpu_hold
);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_WORDS);

   state_t          state;
   logic [1:0]      byte_idx;
   logic [ADDR_W:0] len;
   logic [31:0]     word_buf;
   logic            we_q;

   logic [ADDR_W:0] start_len;
   logic [ADDR_W:0] next_count;
   logic [31:0]     full_word;

   // Requested length clamped to the memory depth so addresses can never wrap.
   assign start_len  = (num_words > DEPTH_L) ? DEPTH_L : num_words;
   assign next_count = word_count + (ADDR_W+1)'(1);
   // Word as it looks once the 4th byte lands; only used when byte_idx is 3.
   assign full_word  = {byte_data, word_buf[23:0]};
   // An abort in the WRITE cycle has to kill the write in that same cycle.
   assign imem_we    = we_q & ~abort;

   // Load sequencer: all outputs except imem_we are registered here.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         byte_idx   <= 2'd0;
         len        <= '0;
         word_buf   <= '0;
         we_q       <= 1'b0;
         byte_ready <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         word_count <= '0;
         checksum   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cpu_hold   <= 1'b1;
      end else begin
         we_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  len        <= start_len;
                  word_count <= '0;
                  checksum   <= '0;
                  byte_idx   <= 2'd0;
                  if (start_len == '0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     cpu_hold <= 1'b0;
                  end else begin
                     state      <= COLLECT;
                     done       <= 1'b0;
                     busy       <= 1'b1;
                     cpu_hold   <= 1'b1;
                     byte_ready <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (abort) begin
                  // Partial word is dropped; the core stays held in reset.
                  state      <= IDLE;
                  busy       <= 1'b0;
                  done       <= 1'b0;
                  byte_ready <= 1'b0;
                  byte_idx   <= 2'd0;
               end else if (byte_valid && byte_ready) begin
                  word_buf[{byte_idx, 3'b000} +: 8] <= byte_data;
                  checksum <= checksum + byte_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     state      <= WRITE;
                     byte_ready <= 1'b0;
                     we_q       <= 1'b1;
                     imem_waddr <= word_count[ADDR_W-1:0];
                     imem_wdata <= full_word;
                  end
               end
            end
            WRITE: begin
               byte_idx <= 2'd0;
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else begin
                  word_count <= next_count;
                  if (next_count == len) begin
                     state    <= DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state      <= COLLECT;
                     byte_ready <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader_rv32i.sv
// Bench for imem_loader_rv32i: directed load scenarios with random byte payloads and stall gaps.
// Expected memory contents and checksum come from a byte-queue reference model.
// Writes are captured at each rising edge into a queue and compared after every load.
module tb_imem_loader_rv32i;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   num_words = '0;
   logic          abort = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = '0;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   word_count;
   logic [7:0]    checksum;
   logic          busy;
   logic          done;
   logic          cpu_hold;

   int n_vec = 0;
   int n_bad = 0;
   logic [36:0] wr_q[$];
   logic [7:0]  stim_q[$];

   imem_loader_rv32i #(.DEPTH_WORDS(32), .ADDR_W(AW)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .num_words(num_words),
      .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .word_count(word_count), .checksum(checksum),
      .busy(busy), .done(done), .cpu_hold(cpu_hold)
   );

   always #5 clock = ~clock;

   // Every committed write, as {addr, data}.
   always @(posedge clock) begin
      if (reset_n && imem_we) wr_q.push_back({imem_waddr, imem_wdata});
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      num_words = n[AW:0];
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_rdy);
      bit ok;
      byte_valid = 1'b0;
      repeat (gap) begin
         if (chk_rdy) chk("rdy_stall", byte_ready, 1);
         tick();
      end
      byte_valid = 1'b1;
      byte_data = b;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (byte_ready) begin
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      byte_valid = 1'b0;
      chk("byte_accept", ok, 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30; i++) begin
         if (done) break;
         tick();
      end
      chk("done", done, 1);
   endtask

   function automatic logic [31:0] model_word(input int w);
      return {stim_q[4*w+3], stim_q[4*w+2], stim_q[4*w+1], stim_q[4*w]};
   endfunction

   function automatic int model_sum(input int nbytes);
      int s = 0;
      for (int i = 0; i < nbytes; i++) s = (s + stim_q[i]) % 256;
      return s;
   endfunction

   task automatic fill_random(input int nbytes);
      stim_q.delete();
      for (int i = 0; i < nbytes; i++) stim_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // Full load of stim_q against the model: clamped length, sequential addresses, LE packing.
   task automatic run_load(input int n_req, input int gap_lo, input int gap_hi);
      int len;
      int base;
      len = (n_req > 32) ? 32 : n_req;
      base = wr_q.size();
      do_start(n_req);
      for (int i = 0; i < 4*len; i++)
         send_byte(stim_q[i], $urandom_range(gap_lo, gap_hi), (i % 4) != 0);
      wait_done();
      chk("write_count", wr_q.size(), base + len);
      for (int w = 0; w < len && base + w < wr_q.size(); w++) begin
         chk("waddr", 32'(wr_q[base+w][36:32]), w);
         chk("wdata", wr_q[base+w][31:0], model_word(w));
      end
      chk("word_count", word_count, len);
      chk("checksum", checksum, model_sum(4*len));
      chk("cpu_hold_rel", cpu_hold, 0);
      chk("busy_end", busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      // Reset state
      repeat (2) tick();
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", byte_ready, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_wc", word_count, 0);
      chk("rst_cksum", checksum, 0);
      chk("rst_waddr", imem_waddr, 0);
      chk("rst_wdata", imem_wdata, 0);
      reset_n = 1'b1;
      tick();

      // Directed two-word program, back-to-back bytes
      stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load(2, 0, 0);
      chk("dir_w0", wr_q[0][31:0], 32'h0000_0013);
      chk("dir_w1", wr_q[1][31:0], 32'h0010_0093);
      chk("dir_cksum", checksum, 8'hB6);

      // Same load with 3 idle cycles before every byte
      run_load(2, 3, 3);

      // Zero-length load
      base = wr_q.size();
      do_start(0);
      chk("len0_ready", byte_ready, 0);
      chk("len0_we", imem_we, 0);
      tick();
      chk("len0_ready2", byte_ready, 0);
      chk("len0_done", done, 1);
      chk("len0_hold", cpu_hold, 0);
      chk("len0_nowrite", wr_q.size(), base);

      // Oversized request clamps to full depth, random bytes and gaps
      fill_random(128);
      run_load(40, 0, 1);
      chk("clamp_last", 32'(wr_q[wr_q.size()-1][36:32]), 31);

      // A few short random loads
      for (int r = 0; r < 3; r++) begin
         int n;
         n = $urandom_range(1, 6);
         fill_random(4*n);
         run_load(n, 0, 2);
      end

      // Abort mid-word after one full word
      fill_random(12);
      base = wr_q.size();
      do_start(3);
      for (int i = 0; i < 6; i++) send_byte(stim_q[i], 0, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_hold", cpu_hold, 1);
      chk("abort_ready", byte_ready, 0);
      chk("abort_wcount", wr_q.size(), base + 1);
      chk("abort_addr", 32'(wr_q[base][36:32]), 0);
      chk("abort_data", wr_q[base][31:0], model_word(0));
      tick();
      chk("abort_idle_we", imem_we, 0);
      fill_random(4);
      run_load(1, 0, 0);

      // Abort in the WRITE cycle suppresses the write
      fill_random(8);
      base = wr_q.size();
      do_start(2);
      for (int i = 0; i < 4; i++) send_byte(stim_q[i], 0, 0);
      abort = 1'b1;
      #1;
      chk("abortw_we", imem_we, 0);
      tick();
      abort = 1'b0;
      chk("abortw_busy", busy, 0);
      chk("abortw_hold", cpu_hold, 1);
      chk("abortw_nowrite", wr_q.size(), base);
      chk("abortw_wc", word_count, 0);

      // start during WRITE is ignored
      fill_random(8);
      base = wr_q.size();
      do_start(2);
      for (int i = 0; i < 4; i++) send_byte(stim_q[i], 0, 0);
      start = 1'b1;
      num_words = 1;
      tick();
      start = 1'b0;
      chk("start_ign_busy", busy, 1);
      for (int i = 4; i < 8; i++) send_byte(stim_q[i], 0, 0);
      wait_done();
      chk("start_ign_wcount", wr_q.size(), base + 2);
      chk("start_ign_wc", word_count, 2);
      chk("start_ign_addr1", 32'(wr_q[base+1][36:32]), 1);
      chk("start_ign_data1", wr_q[base+1][31:0], model_word(1));

      // Asynchronous reset mid-COLLECT
      fill_random(8);
      base = wr_q.size();
      do_start(2);
      send_byte(stim_q[0], 0, 0);
      send_byte(stim_q[1], 0, 0);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_hold", cpu_hold, 1);
      chk("arst_busy", busy, 0);
      chk("arst_ready", byte_ready, 0);
      chk("arst_wc", word_count, 0);
      chk("arst_cksum", checksum, 0);
      chk("arst_done", done, 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("arst_nowrite", wr_q.size(), base);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
